// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N independent button debouncers for the slow control clock.
// Each channel has a 2-flop synchronizer, a debounce FSM with a saturating
// counter, a registered debounced level and one-cycle press/release pulses.
// any_press is the registered OR of the next-cycle press pulses, so it is
// coincident with btn_press.
// Optional feature: define BTN_DEBOUNCE_AUTOREPEAT_EN to add per-channel
// auto-repeat press pulses while a button stays held.
module btn_debounce_multi #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 6100,
  parameter int REPEAT_DELAY    = 12200,
  parameter int REPEAT_PERIOD   = 2440
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            any_press
);

  // One counter width covers every interval, so the same saturating
  // increment serves debounce and repeat timing.
  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    HELD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [N_CH-1:0] press_d_all;
  logic            any_press_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    // rep_phase_q=0 while waiting out the initial delay, 1 once repeating.
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rep_phase_q, rep_phase_d;
`endif

    // Next-state logic for the debounce FSM; pulses default low every cycle.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      rcnt_d      = rcnt_q;
      rep_phase_d = rep_phase_q;
`endif
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_d = WAIT_PRESS;
            cnt_d   = '0;
          end
        end
        WAIT_PRESS: begin
          if (!s2_q) begin
            state_d = IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_d = HELD;
            level_d = 1'b1;
            press_d = 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            rcnt_d      = '0;
            rep_phase_d = 1'b0;
`endif
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        HELD: begin
          if (!s2_q) begin
            state_d = WAIT_RELEASE;
            cnt_d   = '0;
          end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
          else if (rcnt_q == (rep_phase_q ? RP_LAST : RD_LAST)) begin
            press_d     = 1'b1;
            rcnt_d      = '0;
            rep_phase_d = 1'b1;
          end else begin
            rcnt_d = sat_inc(rcnt_q);
          end
`endif
        end
        WAIT_RELEASE: begin
          if (s2_q) begin
            // Bounce back to held: level stays high, no pulse.
            state_d = HELD;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            rcnt_d      = '0;
            rep_phase_d = 1'b0;
`endif
          end else if (cnt_q == DB_LAST) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Synchronizer and FSM registers; reset aborts any count or pulse at once.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        rcnt_q      <= '0;
        rep_phase_q <= 1'b0;
`endif
      end else begin
        s1_q      <= btn_in[gi];
        s2_q      <= s1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        rcnt_q      <= rcnt_d;
        rep_phase_q <= rep_phase_d;
`endif
      end
    end

    assign press_d_all[gi] = press_d;
    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
  end

  // Registering the OR of next-cycle presses keeps any_press aligned with btn_press.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_d_all;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi (N_CH=4, DEBOUNCE_CYCLES=4).
// Stimulus pushes expected pulse events into a scoreboard queue tagged with
// the edge count at which they must appear; a monitor #1 after every rising
// edge pops matching events and checks pulses, any_press and the level.
module tb_btn_debounce_multi;
  localparam int N  = 4;
  localparam int DB = 4;
  // Raw change driven after edge c is first latched at edge c+1 (e0);
  // the pulse is registered at e0+DB+2 = c+DB+3.
  localparam int LAT = DB + 3;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         any_press;

  btn_debounce_multi #(
    .N_CH(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .btn_in(btn_in), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int           at;
    logic [N-1:0] p;
    logic [N-1:0] r;
  } ev_t;
  ev_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int at, input logic [N-1:0] p, input logic [N-1:0] r);
    ev_t e;
    e.at = at; e.p = p; e.r = r;
    sb.push_back(e);
    $display("push: cyc=%0d at=%0d press=%b release=%b", cyc, at, p, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Scoreboard monitor: expected pulses come from the queue, the expected
  // level follows accepted presses/releases and is cleared by reset.
  logic [N-1:0] lvl_m = '0;
  always @(posedge CLK) begin
    logic [N-1:0] ep, er;
    #1;
    ep = '0;
    er = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        ep |= sb[i].p;
        er |= sb[i].r;
        sb.delete(i);
      end
    end
    if (RESET) lvl_m = '0;
    else       lvl_m = (lvl_m | ep) & ~er;
    chk("press",   {28'd0, btn_press},   {28'd0, ep});
    chk("release", {28'd0, btn_release}, {28'd0, er});
    chk("any",     {31'd0, any_press},   {31'd0, |ep});
    chk("level",   {28'd0, btn_level},   {28'd0, lvl_m});
    if (ep != '0 || er != '0)
      $display("pulse: cyc=%0d press=%b release=%b level=%b", cyc, btn_press, btn_release, btn_level);
  end

  initial begin
    int c;
    int r;
    // Reset state
    idle(3);
    chk("rst_level", {28'd0, btn_level}, 32'd0);
    chk("rst_press", {28'd0, btn_press}, 32'd0);
    RESET = 1'b0;
    idle(3);

    // A: clean press on channel 0, with boundary checks on the pulse cycle
    btn_in[0] = 1'b1; c = cyc;
    push(c + LAT, 4'b0001, 4'b0000);
    idle(LAT - 1);
    chk("a_level_before", {31'd0, btn_level[0]}, 32'd0);
    chk("a_press_before", {31'd0, btn_press[0]}, 32'd0);
    idle(1);
    chk("a_level_on", {31'd0, btn_level[0]}, 32'd1);
    chk("a_press_on", {28'd0, btn_press}, 32'd1);
    idle(1);
    chk("a_press_after", {28'd0, btn_press}, 32'd0);
    idle(3);
    btn_in[0] = 1'b0; c = cyc;
    push(c + LAT, 4'b0000, 4'b0001);
    idle(LAT + 3);

    // B: press bounce on channel 1 (3 high, 1 low, then held)
    btn_in[1] = 1'b1; c = cyc;
    idle(3); btn_in[1] = 1'b0;
    idle(1); btn_in[1] = 1'b1;
    push(c + 4 + LAT, 4'b0010, 4'b0000);
    idle(LAT + 4);

    // C: release with a 2-cycle high glitch inside WAIT_RELEASE
    btn_in[1] = 1'b0; c = cyc;
    idle(2); btn_in[1] = 1'b1;
    idle(2); btn_in[1] = 1'b0;
    push(c + 4 + LAT, 4'b0000, 4'b0010);
    idle(4);
    chk("c_level_held", {31'd0, btn_level[1]}, 32'd1);
    idle(LAT + 2);

    // D: channels 0 and 3 rise together
    btn_in[0] = 1'b1; btn_in[3] = 1'b1; c = cyc;
    push(c + LAT, 4'b1001, 4'b0000);
    idle(LAT + 3);

    // E: reset while channel 2 sits at cnt=2 of WAIT_PRESS
    btn_in[2] = 1'b1; c = cyc;
    idle(5);
    RESET = 1'b1;
    #1;
    chk("e_rst_level", {28'd0, btn_level}, 32'd0);
    chk("e_rst_press", {28'd0, btn_press}, 32'd0);
    idle(1);
    RESET = 1'b0; r = cyc;
    push(r + LAT, 4'b1101, 4'b0000);
    idle(LAT + 3);

    // F: release everything
    btn_in = '0; c = cyc;
    push(c + LAT, 4'b0000, 4'b1101);
    idle(LAT + 4);

    chk("queue_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised N-channel successor to the single-button debouncer.
- Per channel: 2-flop input synchronizer, debounce FSM with counter, registered debounced level, one-cycle press pulse and one-cycle release pulse.
- Sits between raw board buttons/switches and the game-control FSM.
- Runs on the slow control clock (~24.4 kHz).

Parameters:
- N_CH, 4: number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 6100: consecutive stable synchronized samples required to accept a press or release (>=1; ~0.25 s at 24.4 kHz).
- REPEAT_DELAY, 12200: cycles held before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 2440: cycles between subsequent auto-repeat pulses. Used only with the optional feature.

Ports:
- CLK  in  1  control clock.
- RESET  in  1  reset, asynchronous, active-high.
- btn_in  in  N_CH  raw, asynchronous, active-high button inputs.
- btn_level  out  N_CH  debounced button state.
- btn_press  out  N_CH  one-cycle pulse per accepted press (plus repeats when enabled).
- btn_release  out  N_CH  one-cycle pulse per accepted release.
- any_press  out  1  registered OR of next-cycle btn_press, coincident with btn_press.

Behaviour:
- Reset is asynchronous, RESET=1:
  - All synchronizer flops, counters and outputs go to 0.
  - Every FSM goes to IDLE.
  - Assertion mid-count or mid-pulse aborts immediately; no pulse is emitted on release of reset.
- Synchronizer: s1<=btn_in, s2<=s1. The FSM samples s2.
  - A raw rising edge captured at clock edge e0 is first seen by the FSM at edge e2.
- Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). Counter saturates, never wraps.
- Per-channel FSM, evaluated at every CLK edge:
  - IDLE: s2=1 -> WAIT_PRESS, cnt<=0.
  - WAIT_PRESS:
    - s2=0 -> IDLE.
    - else if cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, btn_press<=1.
    - else cnt<=cnt+1.
  - HELD: s2=0 -> WAIT_RELEASE, cnt<=0.
  - WAIT_RELEASE:
    - s2=1 -> HELD, no pulse, level stays 1.
    - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0, btn_release<=1.
    - else cnt<=cnt+1.
- Pulse outputs are registered and default to 0 each cycle, so every pulse lasts exactly one cycle.
- Latency, raw input to pulse: btn_press rises after edge e(DEBOUNCE_CYCLES+2) and falls after the next edge. Release is symmetric.
- Glitch rejection:
  - Any s2 glitch shorter than DEBOUNCE_CYCLES samples during WAIT_PRESS returns the channel to IDLE with no output change.
  - A glitch during WAIT_RELEASE returns it to HELD with no output change.
- Channels are fully independent. Simultaneous presses on several channels each pulse in their own computed cycle.
- any_press is high in exactly the cycles where any btn_press bit is high.
- DEBOUNCE_CYCLES=1: a press is accepted after 2 consecutive high samples.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - A per-channel repeat counter rcnt is cleared on entry to HELD from WAIT_PRESS or WAIT_RELEASE, and increments while in HELD.
  - When rcnt reaches REPEAT_DELAY-1, btn_press pulses one cycle. After that, it pulses every REPEAT_PERIOD cycles while the channel stays in HELD.
  - Leaving HELD stops repeats. Returning to HELD from WAIT_RELEASE restarts the delay.
  - btn_level is unaffected.
- Undefined:
  - No rcnt logic is instantiated.
  - btn_press fires exactly once per accepted press.
  - REPEAT_* parameters are ignored.

Test Plan:
- N_CH=4, DEBOUNCE_CYCLES=4: btn_in[0] rises before edge e0 and is held -> btn_press[0]=1 only between e6 and e7; btn_level[0]=1 from e6; other bits stay 0.
- Press bounce: btn_in[1] high for 3 cycles, low for 1, then held -> one btn_press[1], timed from the final rising edge (+6 edges); no earlier pulse.
- Release with a 2-cycle glitch high during WAIT_RELEASE -> no btn_release; after a stable low of 4 samples, btn_release=1 for 1 cycle and btn_level=0.
- Channels 0 and 3 rise in the same cycle -> btn_press=4'b1001 in a single cycle; any_press=1 in that cycle only.
- RESET pulsed while channel 2 is at cnt=2 of WAIT_PRESS -> all outputs 0 immediately; no pulse follows while btn_in stays high until the full 6-edge latency elapses again.
- With BTN_DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, hold 20 cycles -> initial press pulse, then pulses 8, 11, 14, ... cycles after HELD entry; no pulses after release.
